// File: rtl/msg_dispatch_controller.sv
// Dispatches each received message payload from the data RAM to one of NUM_HANDLERS handlers.
// Define MSG_SEQ_CHECK_EN to build the sequence-number check and SeqErrorCount.
module msg_dispatch_controller #(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          NUM_HANDLERS = 4,
    parameter logic [15:0] ID_BASE      = 16'h0100
) (
    input  logic                    Clock,
    input  logic                    Clear_n,
    input  logic                    MessageComplete,
    input  logic [15:0]             MessageID,
    input  logic [15:0]             ByteCount,
    input  logic [15:0]             SequenceNumber,
    input  logic                    ClearDataByteAddr,
    input  logic                    WriteDataByte,
    output logic [ADDR_WIDTH-1:0]   RamAddr,
    input  logic [7:0]              RamReadData,
    output logic [NUM_HANDLERS-1:0] HandlerSelect,
    output logic                    HandlerStart,
    output logic                    HandlerAbort,
    output logic [7:0]              HandlerByte,
    output logic                    HandlerByteValid,
    input  logic                    HandlerByteReady,
    input  logic                    HandlerDone,
    output logic                    Busy,
    output logic [7:0]              RejectCount,
    output logic [7:0]              SeqErrorCount,
    output logic [7:0]              OverrunCount
);

    localparam int          PTR_W   = ADDR_WIDTH + 1;
    localparam logic [16:0] MAX_PAY = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DISPATCH,
        S_READ_ISSUE,
        S_READ_WAIT,
        S_SEND,
        S_WAIT_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_inc;
    logic [15:0]             id_off_q, id_off_d;
    logic [15:0]             pay_len_q, pay_len_d;
    logic [NUM_HANDLERS-1:0] select_q, select_d;
    logic                    start_q, start_d;
    logic                    abort_q, abort_d;
    logic [7:0]              byte_q, byte_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic [7:0]              reject_cnt_q, reject_cnt_d;
    logic [7:0]              overrun_cnt_q, overrun_cnt_d;
`ifdef MSG_SEQ_CHECK_EN
    logic [15:0]             seq_num_q, seq_num_d;
    logic [15:0]             exp_seq_q, exp_seq_d;
    logic                    exp_valid_q, exp_valid_d;
    logic [7:0]              seq_err_cnt_q, seq_err_cnt_d;
`else
    logic                    unused_seq;
    assign unused_seq = ^SequenceNumber;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        id_off_d      = id_off_q;
        pay_len_d     = pay_len_q;
        select_d      = select_q;
        start_d       = 1'b0;
        abort_d       = 1'b0;
        byte_d        = byte_q;
        valid_d       = valid_q;
        reject_cnt_d  = reject_cnt_q;
        overrun_cnt_d = overrun_cnt_q;
`ifdef MSG_SEQ_CHECK_EN
        seq_num_d     = seq_num_q;
        exp_seq_d     = exp_seq_q;
        exp_valid_d   = exp_valid_q;
        seq_err_cnt_d = seq_err_cnt_q;
`endif

        if (ClearDataByteAddr) begin
            wr_ptr_d = '0;
        end else if (WriteDataByte) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (MessageComplete) begin
                    id_off_d  = MessageID - ID_BASE;
                    pay_len_d = (ByteCount > 16'd8) ? ByteCount - 16'd8 : 16'd0;
`ifdef MSG_SEQ_CHECK_EN
                    seq_num_d = SequenceNumber;
`endif
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                // IDs below ID_BASE wrap to large offsets and are rejected too
                if (id_off_q >= 16'(NUM_HANDLERS) || {1'b0, pay_len_q} > MAX_PAY) begin
                    reject_cnt_d = sat_inc(reject_cnt_q);
                    state_d      = S_IDLE;
                end else begin
`ifdef MSG_SEQ_CHECK_EN
                    if (exp_valid_q && seq_num_q != exp_seq_q) begin
                        seq_err_cnt_d = sat_inc(seq_err_cnt_q);
                    end
                    exp_seq_d   = seq_num_q + 16'd1;
                    exp_valid_d = 1'b1;
`endif
                    for (int k = 0; k < NUM_HANDLERS; k++) begin
                        select_d[k] = (id_off_q == 16'(k));
                    end
                    start_d  = 1'b1;
                    rd_ptr_d = '0;
                    state_d  = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                state_d = (pay_len_q == 16'd0) ? S_WAIT_DONE : S_READ_ISSUE;
            end
            S_READ_ISSUE: begin
                state_d = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                byte_d  = RamReadData;
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (HandlerByteReady) begin
                    valid_d  = 1'b0;
                    rd_ptr_d = rd_ptr_inc;
                    state_d  = (rd_ptr_inc == pay_len_q[PTR_W-1:0]) ? S_WAIT_DONE : S_READ_ISSUE;
                end
            end
            S_WAIT_DONE: begin
                if (HandlerDone) begin
                    select_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new payload or header arriving mid-transfer is an overrun; a new payload also aborts
        if (state_q != S_IDLE) begin
            if (ClearDataByteAddr || MessageComplete) begin
                overrun_cnt_d = sat_inc(overrun_cnt_q);
            end
            if (ClearDataByteAddr) begin
                abort_d  = 1'b1;
                start_d  = 1'b0;
                valid_d  = 1'b0;
                select_d = '0;
                state_d  = S_IDLE;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            id_off_q      <= '0;
            pay_len_q     <= '0;
            select_q      <= '0;
            start_q       <= 1'b0;
            abort_q       <= 1'b0;
            byte_q        <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            reject_cnt_q  <= '0;
            overrun_cnt_q <= '0;
`ifdef MSG_SEQ_CHECK_EN
            seq_num_q     <= '0;
            exp_seq_q     <= '0;
            exp_valid_q   <= 1'b0;
            seq_err_cnt_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            id_off_q      <= id_off_d;
            pay_len_q     <= pay_len_d;
            select_q      <= select_d;
            start_q       <= start_d;
            abort_q       <= abort_d;
            byte_q        <= byte_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            reject_cnt_q  <= reject_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
`ifdef MSG_SEQ_CHECK_EN
            seq_num_q     <= seq_num_d;
            exp_seq_q     <= exp_seq_d;
            exp_valid_q   <= exp_valid_d;
            seq_err_cnt_q <= seq_err_cnt_d;
`endif
        end
    end

    assign RamAddr          = WriteDataByte ? wr_ptr_q : rd_ptr_q[ADDR_WIDTH-1:0];
    assign HandlerSelect    = select_q;
    assign HandlerStart     = start_q;
    assign HandlerAbort     = abort_q;
    assign HandlerByte      = byte_q;
    assign HandlerByteValid = valid_q;
    assign Busy             = busy_q;
    assign RejectCount      = reject_cnt_q;
    assign OverrunCount     = overrun_cnt_q;
`ifdef MSG_SEQ_CHECK_EN
    assign SeqErrorCount    = seq_err_cnt_q;
`else
    assign SeqErrorCount    = 8'd0;
`endif

endmodule

// File: tb/tb_msg_dispatch_controller.sv
// Self-checking bench for msg_dispatch_controller: emulates the demux and data RAM,
// and predicts dispatch/reject outcomes, payload bytes and counters from message rules.
module tb_msg_dispatch_controller;

    localparam int ADDR_WIDTH   = 10;
    localparam int NUM_HANDLERS = 4;
    localparam int ID_BASE      = 256;
    localparam int MAX_PAY      = 1024;

    logic                    Clock = 1'b0;
    logic                    Clear_n;
    logic                    MessageComplete;
    logic [15:0]             MessageID;
    logic [15:0]             ByteCount;
    logic [15:0]             SequenceNumber;
    logic                    ClearDataByteAddr;
    logic                    WriteDataByte;
    logic [ADDR_WIDTH-1:0]   RamAddr;
    logic [7:0]              RamReadData;
    logic [NUM_HANDLERS-1:0] HandlerSelect;
    logic                    HandlerStart;
    logic                    HandlerAbort;
    logic [7:0]              HandlerByte;
    logic                    HandlerByteValid;
    logic                    HandlerByteReady;
    logic                    HandlerDone;
    logic                    Busy;
    logic [7:0]              RejectCount;
    logic [7:0]              SeqErrorCount;
    logic [7:0]              OverrunCount;

    logic [7:0] wr_data;
    logic [7:0] ram [0:MAX_PAY-1];
    logic [7:0] payload_q [$];

    int errors = 0;
    int checks = 0;
    int exp_reject = 0;
    int exp_seqerr = 0;
    int exp_overrun = 0;
    bit seq_valid = 1'b0;
    int seq_expect = 0;

    msg_dispatch_controller #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .NUM_HANDLERS (NUM_HANDLERS),
        .ID_BASE      (16'h0100)
    ) dut (
        .Clock             (Clock),
        .Clear_n           (Clear_n),
        .MessageComplete   (MessageComplete),
        .MessageID         (MessageID),
        .ByteCount         (ByteCount),
        .SequenceNumber    (SequenceNumber),
        .ClearDataByteAddr (ClearDataByteAddr),
        .WriteDataByte     (WriteDataByte),
        .RamAddr           (RamAddr),
        .RamReadData       (RamReadData),
        .HandlerSelect     (HandlerSelect),
        .HandlerStart      (HandlerStart),
        .HandlerAbort      (HandlerAbort),
        .HandlerByte       (HandlerByte),
        .HandlerByteValid  (HandlerByteValid),
        .HandlerByteReady  (HandlerByteReady),
        .HandlerDone       (HandlerDone),
        .Busy              (Busy),
        .RejectCount       (RejectCount),
        .SeqErrorCount     (SeqErrorCount),
        .OverrunCount      (OverrunCount)
    );

    always #5 Clock = ~Clock;

    // Synchronous data RAM with one cycle of read latency
    always @(posedge Clock) begin
        if (WriteDataByte) ram[RamAddr] <= wr_data;
        RamReadData <= ram[RamAddr];
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int satInc(input int v);
        return (v < 255) ? v + 1 : 255;
    endfunction

    function automatic int payOf(input int bc);
        return (bc > 8) ? bc - 8 : 0;
    endfunction

    function automatic bit isAccepted(input int id, input int bc);
        return (id - ID_BASE >= 0) && (id - ID_BASE < NUM_HANDLERS) && (payOf(bc) <= MAX_PAY);
    endfunction

    task automatic modelCheck(input int id, input int bc, input int seq, output bit acc);
        acc = isAccepted(id, bc);
        if (!acc) begin
            exp_reject = satInc(exp_reject);
        end else begin
`ifdef MSG_SEQ_CHECK_EN
            if (seq_valid && seq != seq_expect) exp_seqerr = satInc(exp_seqerr);
`endif
            seq_expect = (seq + 1) % 65536;
            seq_valid  = 1'b1;
        end
    endtask

    task automatic checkCounters();
        checkOutput("reject_count", 32'(RejectCount), 32'(exp_reject));
        checkOutput("seq_error_count", 32'(SeqErrorCount), 32'(exp_seqerr));
        checkOutput("overrun_count", 32'(OverrunCount), 32'(exp_overrun));
    endtask

    // Demux emulation: clear the write pointer, write the payload, then pulse the header
    task automatic loadMessage(input int id, input int bc, input int seq, input bit fixed);
        int pay;
        pay = payOf(bc);
        ClearDataByteAddr = 1'b1;
        step();
        ClearDataByteAddr = 1'b0;
        payload_q.delete();
        if (pay <= MAX_PAY) begin
            for (int i = 0; i < pay; i++) begin
                wr_data = fixed ? 8'(8'hA0 + i) : 8'($urandom);
                payload_q.push_back(wr_data);
                WriteDataByte = 1'b1;
                step();
            end
        end
        WriteDataByte   = 1'b0;
        MessageID       = 16'(id);
        ByteCount       = 16'(bc);
        SequenceNumber  = 16'(seq);
        MessageComplete = 1'b1;
        step();
        MessageComplete = 1'b0;
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready pattern 1-0-0-1
    task automatic runMessage(input int id, input int bc, input int seq, input int mode, input bit timing);
        bit acc;
        bit pending;
        bit r;
        int pay, received, cycles, vcount, delay;
        logic [7:0] held;
        pay = payOf(bc);
        checkOutput("busy_in_check", 32'(Busy), 32'd1);
        checkOutput("no_start_in_check", 32'(HandlerStart), 32'd0);
        modelCheck(id, bc, seq, acc);
        step();
        if (!acc) begin
            checkOutput("reject_no_start", 32'(HandlerStart), 32'd0);
            checkOutput("reject_idle", 32'(Busy), 32'd0);
            checkOutput("reject_select", 32'(HandlerSelect), 32'd0);
            checkCounters();
            return;
        end
        checkOutput("start_pulse", 32'(HandlerStart), 32'd1);
        checkOutput("select_onehot", 32'(HandlerSelect), 32'(1) << (id - ID_BASE));
        received = 0;
        cycles   = 0;
        vcount   = 0;
        pending  = 1'b0;
        held     = 8'h00;
        while (received < pay && cycles < 20 * pay + 20) begin
            step();
            cycles++;
            if (cycles == 1) checkOutput("start_one_cycle", 32'(HandlerStart), 32'd0);
            if (timing && received == 0 && cycles <= 3)
                checkOutput("first_valid_latency", 32'(HandlerByteValid), 32'(cycles == 3));
            if (HandlerByteValid) begin
                if (pending) checkOutput("byte_stable", 32'(HandlerByte), 32'(held));
                case (mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = (vcount % 4 == 0) || (vcount % 4 == 3);
                endcase
                vcount++;
                HandlerByteReady = r;
                if (r) begin
                    checkOutput("payload_byte", 32'(HandlerByte), 32'(payload_q[received]));
                    received++;
                    pending = 1'b0;
                    if (mode == 0 && timing) checkOutput("byte_cadence", 32'(cycles), 32'(3 * received));
                end else begin
                    pending = 1'b1;
                    held    = HandlerByte;
                end
            end else begin
                HandlerByteReady = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        checkOutput("all_bytes_delivered", 32'(received), 32'(pay));
        step();
        HandlerByteReady = 1'b0;
        if (pay == 0) checkOutput("start_one_cycle", 32'(HandlerStart), 32'd0);
        checkOutput("valid_low_after_last", 32'(HandlerByteValid), 32'd0);
        checkOutput("busy_wait_done", 32'(Busy), 32'd1);
        checkOutput("select_held", 32'(HandlerSelect), 32'(1) << (id - ID_BASE));
        delay = $urandom_range(0, 3);
        for (int d = 0; d < delay; d++) step();
        HandlerDone = 1'b1;
        step();
        HandlerDone = 1'b0;
        checkOutput("idle_after_done", 32'(Busy), 32'd0);
        checkOutput("select_cleared", 32'(HandlerSelect), 32'd0);
        checkCounters();
    endtask

    task automatic applyStimulus(input int id, input int bc, input int seq, input int mode, input bit timing);
        loadMessage(id, bc, seq, 1'b0);
        runMessage(id, bc, seq, mode, timing);
    endtask

    initial begin
        bit acc;
        int rid, rbc, rseq, rmode;
        Clear_n           = 1'b0;
        MessageComplete   = 1'b0;
        MessageID         = 16'h0000;
        ByteCount         = 16'h0000;
        SequenceNumber    = 16'h0000;
        ClearDataByteAddr = 1'b0;
        WriteDataByte     = 1'b0;
        wr_data           = 8'h00;
        HandlerByteReady  = 1'b0;
        HandlerDone       = 1'b0;
        step();
        step();
        checkOutput("reset_select", 32'(HandlerSelect), 32'd0);
        checkOutput("reset_start", 32'(HandlerStart), 32'd0);
        checkOutput("reset_abort", 32'(HandlerAbort), 32'd0);
        checkOutput("reset_byte", 32'(HandlerByte), 32'd0);
        checkOutput("reset_valid", 32'(HandlerByteValid), 32'd0);
        checkOutput("reset_busy", 32'(Busy), 32'd0);
        checkOutput("reset_ramaddr", 32'(RamAddr), 32'd0);
        checkCounters();
        Clear_n = 1'b1;
        step();

        $display("[TB] basic dispatch of ID 0x0102 with A0..A3");
        loadMessage(16'h0102, 12, 0, 1'b1);
        runMessage(16'h0102, 12, 0, 0, 1'b1);

        $display("[TB] unknown ID rejected");
        applyStimulus(16'h0200, 8, 1, 0, 1'b0);

        $display("[TB] ready pattern 1-0-0-1");
        applyStimulus(16'h0101, 13, seq_expect, 2, 1'b0);

        $display("[TB] payload overwrite aborts, coinciding header counts once");
        loadMessage(16'h0101, 12, seq_expect, 1'b0);
        modelCheck(16'h0101, 12, seq_expect, acc);
        HandlerByteReady = 1'b0;
        for (int i = 0; i < 10 && !HandlerByteValid; i++) step();
        checkOutput("ovr_valid_before", 32'(HandlerByteValid), 32'd1);
        ClearDataByteAddr = 1'b1;
        MessageComplete   = 1'b1;
        step();
        ClearDataByteAddr = 1'b0;
        MessageComplete   = 1'b0;
        exp_overrun = satInc(exp_overrun);
        checkOutput("ovr_abort_pulse", 32'(HandlerAbort), 32'd1);
        checkOutput("ovr_valid_drop", 32'(HandlerByteValid), 32'd0);
        checkOutput("ovr_select_drop", 32'(HandlerSelect), 32'd0);
        checkOutput("ovr_idle", 32'(Busy), 32'd0);
        checkCounters();
        step();
        checkOutput("ovr_abort_one_cycle", 32'(HandlerAbort), 32'd0);
        applyStimulus(16'h0103, 11, seq_expect, 1, 1'b0);

        $display("[TB] header arriving while waiting for done");
        loadMessage(16'h0100, 8, seq_expect, 1'b0);
        modelCheck(16'h0100, 8, seq_expect, acc);
        step();
        step();
        MessageID       = 16'h0103;
        ByteCount       = 16'd8;
        MessageComplete = 1'b1;
        step();
        MessageComplete = 1'b0;
        exp_overrun = satInc(exp_overrun);
        checkOutput("hdr_ovr_busy", 32'(Busy), 32'd1);
        checkOutput("hdr_ovr_select", 32'(HandlerSelect), 32'd1);
        checkOutput("hdr_ovr_no_start", 32'(HandlerStart), 32'd0);
        checkCounters();
        HandlerDone = 1'b1;
        step();
        HandlerDone = 1'b0;
        checkOutput("hdr_ovr_idle", 32'(Busy), 32'd0);

        $display("[TB] length and ID boundaries");
        applyStimulus(16'h0103, 5, seq_expect, 0, 1'b0);
        applyStimulus(16'h0102, 8 + MAX_PAY, seq_expect, 0, 1'b1);
        applyStimulus(16'h0101, 9 + MAX_PAY, seq_expect, 0, 1'b0);
        applyStimulus(16'h00FF, 10, seq_expect, 0, 1'b0);

        $display("[TB] randomized messages");
        for (int n = 0; n < 25; n++) begin
            rid   = ID_BASE - 1 + int'($urandom_range(0, 6));
            rbc   = int'($urandom_range(0, 14));
            rseq  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : seq_expect;
            rmode = int'($urandom_range(0, 2));
            applyStimulus(rid, rbc, rseq, rmode, 1'b0);
        end

        $display("[TB] asynchronous reset mid-transfer");
        loadMessage(16'h0101, 14, seq_expect, 1'b0);
        modelCheck(16'h0101, 14, seq_expect, acc);
        HandlerByteReady = 1'b0;
        for (int i = 0; i < 10 && !HandlerByteValid; i++) step();
        checkOutput("pre_reset_valid", 32'(HandlerByteValid), 32'd1);
        #2;
        Clear_n = 1'b0;
        #1;
        exp_reject  = 0;
        exp_seqerr  = 0;
        exp_overrun = 0;
        seq_valid   = 1'b0;
        seq_expect  = 0;
        checkOutput("async_select", 32'(HandlerSelect), 32'd0);
        checkOutput("async_valid", 32'(HandlerByteValid), 32'd0);
        checkOutput("async_byte", 32'(HandlerByte), 32'd0);
        checkOutput("async_busy", 32'(Busy), 32'd0);
        checkOutput("async_ramaddr", 32'(RamAddr), 32'd0);
        checkCounters();
        step();
        Clear_n = 1'b1;
        step();

        $display("[TB] sequence 5 then 7");
        applyStimulus(16'h0100, 10, 5, 0, 1'b0);
        applyStimulus(16'h0101, 9, 7, 0, 1'b0);

        $display("[TB] reject counter saturation");
        for (int n = 0; n < 300; n++) begin
            MessageID       = 16'h0200;
            ByteCount       = 16'd8;
            MessageComplete = 1'b1;
            step();
            MessageComplete = 1'b0;
            modelCheck(16'h0200, 8, 0, acc);
            step();
        end
        checkOutput("reject_saturated", 32'(RejectCount), 32'd255);
        checkCounters();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
